// File: rtl/mips_check_pkg.sv
// mips_check_pkg: shared types for the store-bus checker
package mips_check_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } store_entry_t;
  typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} chk_state_t;
endpackage

// File: rtl/store_checker_if.sv
// store_checker_if: store bus, table programming and verdict signals of store_checker
interface store_checker_if #(parameter int DEPTH = 8);
  localparam int IW = $clog2(DEPTH);
  logic          memwrite;
  logic [31:0]   dataadr, writedata;
  logic          prog_we;
  logic [IW-1:0] prog_idx;
  logic [31:0]   prog_addr, prog_data;
  logic [IW:0]   prog_count;
  logic          start;
  logic          busy, done, pass, timeout;
  logic [IW-1:0] fail_idx;
  logic [31:0]   fail_addr, fail_data;
  modport master(
    output memwrite, dataadr, writedata, prog_we, prog_idx, prog_addr, prog_data, prog_count, start,
    input  busy, done, pass, timeout, fail_idx, fail_addr, fail_data
  );
  modport slave(
    input  memwrite, dataadr, writedata, prog_we, prog_idx, prog_addr, prog_data, prog_count, start,
    output busy, done, pass, timeout, fail_idx, fail_addr, fail_data
  );
endinterface

// File: rtl/store_table.sv
// store_table: DEPTH-entry expected-store register file, one write port,
// one combinational read port, asynchronous active-low clear
module store_table import mips_check_pkg::*; #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] widx,
  input  store_entry_t             wentry,
  input  logic [$clog2(DEPTH)-1:0] ridx,
  output store_entry_t             rentry
);
  store_entry_t mem [DEPTH];
  always_ff @(posedge clk or negedge reset)
    if (!reset) for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    else if (we) mem[widx] <= wentry;
  assign rentry = mem[ridx];
endmodule

// File: rtl/store_checker.sv
// store_checker: checks processor stores in order against a programmed table of
// expected (address, data) pairs. Optional watchdog: STORE_CHECK_TIMEOUT_EN.
module store_checker import mips_check_pkg::*; #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1024
) (
  input logic            clk,
  input logic            reset,
  store_checker_if.slave bus
);
  localparam int IW = $clog2(DEPTH);
  localparam logic [IW:0] DMAX = (IW+1)'(DEPTH);
  chk_state_t    state;
  logic [IW-1:0] ptr, fail_idx;
  logic [IW:0]   count, count_sat;
  logic [31:0]   fail_addr, fail_data;
  store_entry_t  exp_e;
  logic          hit, last;
  store_table #(.DEPTH(DEPTH)) u_table (
    .clk   (clk),
    .reset (reset),
    .we    (bus.prog_we && state != RUN),
    .widx  (bus.prog_idx),
    .wentry(store_entry_t'({bus.prog_addr, bus.prog_data})),
    .ridx  (ptr),
    .rentry(exp_e)
  );
  assign count_sat = bus.prog_count > DMAX ? DMAX : bus.prog_count;
  // === so that X/Z on the bus never counts as a match in simulation
  assign hit  = {bus.dataadr, bus.writedata} === exp_e;
  assign last = {1'b0, ptr} == count - 1'b1;
`ifdef STORE_CHECK_TIMEOUT_EN
  localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] wd;
  logic          tmo;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wd  <= '0;
      tmo <= 1'b0;
    end else if (state == RUN) begin
      wd  <= wd + 1'b1;
      tmo <= !(bus.memwrite && (!hit || last)) && wd == TW'(TIMEOUT - 1);
    end else if (bus.start) begin
      wd  <= '0;
      tmo <= 1'b0;
    end
  assign bus.timeout = tmo;
`else
  assign bus.timeout = TIMEOUT < 0;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state     <= IDLE;
      ptr       <= '0;
      count     <= '0;
      fail_idx  <= '0;
      fail_addr <= '0;
      fail_data <= '0;
    end else if (state == RUN) begin
      if (bus.memwrite && !hit) begin
        state     <= FAIL;
        fail_idx  <= ptr;
        fail_addr <= bus.dataadr;
        fail_data <= bus.writedata;
      end else if (bus.memwrite && last) begin
        state <= PASS;
      end else begin
        if (bus.memwrite) ptr <= ptr + 1'b1;
`ifdef STORE_CHECK_TIMEOUT_EN
        if (wd == TW'(TIMEOUT - 1)) begin
          state    <= FAIL;
          fail_idx <= ptr;
        end
`endif
      end
    end else if (bus.start) begin
      state     <= count_sat == '0 ? PASS : RUN;
      count     <= count_sat;
      ptr       <= '0;
      fail_idx  <= '0;
      fail_addr <= '0;
      fail_data <= '0;
    end
  assign bus.busy      = state == RUN;
  assign bus.done      = state == PASS || state == FAIL;
  assign bus.pass      = state == PASS;
  assign bus.fail_idx  = fail_idx;
  assign bus.fail_addr = fail_addr;
  assign bus.fail_data = fail_data;
endmodule

// File: tb/tb_store_checker.sv
// tb_store_checker: scoreboard bench for store_checker; watchdog cases run when
// STORE_CHECK_TIMEOUT_EN is defined
module tb_store_checker;
  import mips_check_pkg::*;
  localparam int DEPTH = 8;
  localparam int IW = $clog2(DEPTH);
  typedef struct {
    logic          pass;
    logic          tmo;
    logic [IW-1:0] idx;
    logic [31:0]   addr;
    logic [31:0]   data;
  } verdict_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  store_checker_if #(.DEPTH(DEPTH)) bus ();
  store_checker #(.DEPTH(DEPTH), .TIMEOUT(16)) dut (.clk(clk), .reset(reset), .bus(bus));
  verdict_t     exp_q[$];
  store_entry_t model_tab[DEPTH];
  logic         m_run = 1'b0;
  int           m_ptr = 0;
  int           m_count = 0;
  int           checks = 0;
  int           failures = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic push(input logic p, input logic t, input int idx, input logic [31:0] a, input logic [31:0] d);
    verdict_t v;
    v.pass = p; v.tmo = t; v.idx = IW'(idx); v.addr = a; v.data = d;
    exp_q.push_back(v);
    m_run = 1'b0;
  endtask
  task automatic prog(input int idx, input logic [31:0] a, input logic [31:0] d);
    bus.prog_we = 1'b1; bus.prog_idx = IW'(idx); bus.prog_addr = a; bus.prog_data = d;
    if (!m_run) model_tab[idx] = {a, d};
    tick();
    bus.prog_we = 1'b0;
  endtask
  task automatic start(input int cnt, input logic st, input logic [31:0] a, input logic [31:0] d);
    bus.prog_count = (IW+1)'(cnt); bus.start = 1'b1;
    bus.memwrite = st; bus.dataadr = a; bus.writedata = d;
    if (!m_run) begin
      m_count = cnt > DEPTH ? DEPTH : cnt;
      m_ptr = 0;
      if (m_count == 0) push(1'b1, 1'b0, 0, 0, 0);
      else m_run = 1'b1;
    end
    tick();
    bus.start = 1'b0; bus.memwrite = 1'b0;
  endtask
  task automatic store(input logic [31:0] a, input logic [31:0] d);
    bus.memwrite = 1'b1; bus.dataadr = a; bus.writedata = d;
    if (m_run) begin
      if (model_tab[m_ptr] != {a, d}) push(1'b0, 1'b0, m_ptr, a, d);
      else if (m_ptr == m_count - 1) push(1'b1, 1'b0, 0, 0, 0);
      else m_ptr++;
    end
    tick();
    bus.memwrite = 1'b0; bus.dataadr = $urandom; bus.writedata = $urandom;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic expect_verdict(input string tag);
    verdict_t e;
    int n = 0;
    while (!bus.done && n < 40) begin tick(); n++; end
    check({tag, ".done"}, bus.done, 1'b1);
    check({tag, ".queue"}, exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, ".pass"}, bus.pass, e.pass);
      check({tag, ".timeout"}, bus.timeout, e.tmo);
      check({tag, ".busy"}, bus.busy, 1'b0);
      check({tag, ".fail_idx"}, bus.fail_idx, e.idx);
      check({tag, ".fail_addr"}, bus.fail_addr, e.addr);
      check({tag, ".fail_data"}, bus.fail_data, e.data);
    end
  endtask
  initial begin
    bus.memwrite = 0; bus.dataadr = 0; bus.writedata = 0; bus.prog_we = 0; bus.prog_idx = 0;
    bus.prog_addr = 0; bus.prog_data = 0; bus.prog_count = 0; bus.start = 0;
    for (int i = 0; i < DEPTH; i++) model_tab[i] = '0;
    #2 reset = 1'b0;
    #1;
    check("rst.busy", bus.busy, 1'b0);
    check("rst.done", bus.done, 1'b0);
    check("rst.pass", bus.pass, 1'b0);
    check("rst.timeout", bus.timeout, 1'b0);
    check("rst.fail_idx", bus.fail_idx, 0);
    check("rst.fail_addr", bus.fail_addr, 0);
    check("rst.fail_data", bus.fail_data, 0);
    idle(2);
    reset = 1'b1;
    tick();
    prog(0, 84, 7);
    start(1, 1'b0, 0, 0);
    check("single.busy_rise", bus.busy, 1'b1);
    store(84, 7);
    expect_verdict("single");
    start(1, 1'b0, 0, 0);
    store(84, 8);
    expect_verdict("mismatch");
    prog(0, 80, 7); prog(1, 84, 7); prog(2, 88, 3);
    start(3, 1'b0, 0, 0);
    store(80, 7); idle(2); store(84, 7); idle(5); store(88, 3);
    expect_verdict("seq_gaps");
    start(3, 1'b0, 0, 0);
    store(80, 7); store(84, 7); store(88, 3);
    expect_verdict("seq_b2b");
    start(3, 1'b0, 0, 0);
    store(80, 7); store(88, 3);
    expect_verdict("seq_swap");
    start(0, 1'b1, 84, 7);
    expect_verdict("empty");
    start(1, 1'b1, 84, 99);
    check("start_store.busy", bus.busy, 1'b1);
    store(80, 7);
    expect_verdict("start_store");
    for (int i = 0; i < DEPTH; i++) prog(i, $urandom, $urandom);
    start(15, 1'b0, 0, 0);
    for (int i = 0; i < DEPTH; i++) store(model_tab[i].addr, model_tab[i].data);
    expect_verdict("saturate");
    start(2, 1'b0, 0, 0);
    start(0, 1'b0, 0, 0);
    check("start_in_run.busy", bus.busy, 1'b1);
    prog(1, 32'hdead, 32'hbeef);
    store(model_tab[0].addr, model_tab[0].data);
    store(model_tab[1].addr, model_tab[1].data);
    expect_verdict("frozen_table");
    bus.prog_we = 1'b1; bus.prog_idx = 0; bus.prog_addr = 200; bus.prog_data = 300;
    model_tab[0] = {32'd200, 32'd300};
    start(1, 1'b0, 0, 0);
    bus.prog_we = 1'b0;
    store(200, 300);
    expect_verdict("we_and_start");
    prog(0, 80, 7); prog(1, 84, 7); prog(2, 88, 3);
    start(3, 1'b0, 0, 0);
    store(80, 7);
    #2 reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_tab[i] = '0;
    m_run = 1'b0;
    #1;
    check("midrst.busy", bus.busy, 1'b0);
    check("midrst.done", bus.done, 1'b0);
    check("midrst.pass", bus.pass, 1'b0);
    check("midrst.state", dut.state, IDLE);
    idle(2);
    reset = 1'b1;
    tick();
    start(1, 1'b0, 0, 0);
    store(0, 0);
    expect_verdict("midrst.readback");
    start(0, 1'b0, 0, 0);
    expect_verdict("midrst.empty");
`ifdef STORE_CHECK_TIMEOUT_EN
    prog(0, 84, 7);
    start(1, 1'b0, 0, 0);
    begin
      int n = 0;
      while (!bus.done && n < 40) begin tick(); n++; end
      check("wd.cycles", n, 16);
    end
    push(1'b0, 1'b1, 0, 0, 0);
    expect_verdict("wd");
    start(1, 1'b0, 0, 0);
    idle(15);
    store(84, 7);
    expect_verdict("wd_last_store");
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/store_checker.md
# store_checker

- Synthesizable store-bus checker on the data-memory write port of `mipstop` (`memwrite`, `dataadr`, `writedata`).
- Compares the processor's stores, in order, against a programmed table of expected (address, data) pairs.
- Reports a registered pass/fail verdict and the first mismatch.
- Allows self-checking both in simulation benches and on FPGA, where the verdict drives LEDs.

## Interface

Parameters:

- `DEPTH`, default 8: number of expected-store table entries (power of two, at least 2).
- `TIMEOUT`, default 1024: watchdog limit in RUN-state cycles. Only used with `STORE_CHECK_TIMEOUT_EN`.

Ports:

- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `memwrite`, input, 1: store strobe from the processor.
- `dataadr`, input, 32: store byte address.
- `writedata`, input, 32: store data.
- `prog_we`, input, 1: write one table entry.
- `prog_idx`, input, `$clog2(DEPTH)`: table entry index.
- `prog_addr`, input, 32: expected address for the entry.
- `prog_data`, input, 32: expected data for the entry.
- `prog_count`, input, `$clog2(DEPTH)+1`: number of valid entries. Sampled on `start`; values greater than DEPTH saturate to DEPTH.
- `start`, input, 1: one-cycle pulse that begins checking.
- `busy`, output, 1: high while in RUN.
- `done`, output, 1: high in PASS or FAIL.
- `pass`, output, 1: high in PASS only.
- `timeout`, output, 1: the failure was caused by the watchdog.
- `fail_idx`, output, `$clog2(DEPTH)`: table index at the first mismatch.
- `fail_addr`, output, 32: observed address at the first mismatch.
- `fail_data`, output, 32: observed data at the first mismatch.

## Operation

States:

- IDLE:
  - `prog_we` writes `{prog_addr, prog_data}` into entry `prog_idx`.
  - `start` latches the count and clears the pointer, the fail fields and the timeout flag.
  - After `start`: count 0 → PASS; otherwise → RUN.
- RUN: each rising edge with `memwrite=1` compares `{dataadr, writedata}` against `table[ptr]`.
  - Exact match on both fields and `ptr==count-1` → PASS.
  - Exact match otherwise → `ptr++`, stay in RUN.
  - Any mismatch → FAIL; capture `fail_idx=ptr`, `fail_addr=dataadr`, `fail_data=writedata`.
- PASS / FAIL:
  - Hold the verdict; further stores are ignored.
  - `start` re-arms: same transitions as from IDLE.
  - Table contents are kept across the re-arm.

Rules:

- `prog_we` is ignored outside IDLE, PASS and FAIL, so the table is frozen during RUN.
- `start` in RUN is ignored.
- `prog_we` and `start` in the same cycle: the write lands first; the count comes from `prog_count` that cycle.
- Stores with `memwrite=0` are never compared.
- A store presented in the same cycle as `start` is not checked.
- Comparisons use `===` semantics in simulation. X/Z on `dataadr` or `writedata` while `memwrite=1` counts as a mismatch.

Reset (`reset=0`, immediate):

- State → IDLE.
- All table entries → 0; pointer and count → 0.
- `busy`, `done`, `pass` and `timeout` → 0.
- `fail_idx`, `fail_addr` and `fail_data` → 0.
- Reset mid-RUN abandons the check with no verdict.

## Timing

- All outputs are registered; there is no combinational input-to-output path.
- `busy` rises the cycle after `start`.
- Verdict latency: `done` and `pass` (or `fail_*`) are valid at the edge where the deciding store is sampled. They are visible one cycle after the store is presented.
- Back-to-back stores (`memwrite` high on consecutive cycles) are checked at one per cycle, with no stall.
- Count 0: `done=pass=1` one cycle after `start`.

## Configuration

Macro `STORE_CHECK_TIMEOUT_EN`:

- Defined:
  - A cycle counter clears on entry to RUN and increments every RUN cycle.
  - When it reaches `TIMEOUT-1` with no verdict, the next edge → FAIL with `timeout=1`, `fail_idx=ptr`, and `fail_addr`/`fail_data` left at 0.
  - A deciding store on the same edge takes priority over the timeout.
- Undefined:
  - No counter; RUN lasts until a verdict.
  - `timeout` is tied to 0.
  - `TIMEOUT` is unused.

## Structure

- Shared package `mips_check_pkg` holds:
  - `store_entry_t`, a packed struct `{addr[31:0], data[31:0]}`.
  - `chk_state_t`, an enum: IDLE, RUN, PASS, FAIL.
- One sub-module, `store_table`: DEPTH-entry register file with one write port, one combinational read port and async active-low clear.
- The FSM, pointer, compare and watchdog live in `store_checker`.

## Test plan

- **Single store, pass:** program entry 0 = (84, 7), count 1, pulse `start`, drive `memwrite`/84/7. Next cycle `done=1`, `pass=1`, `busy=0`.
- **Data mismatch:** program entry 0 = (84, 7), count 1, drive 84/8. Result: `done=1`, `pass=0`, `fail_idx=0`, `fail_addr=84`, `fail_data=8`.
- **Three-entry sequence:** program (80, 7), (84, 7), (88, 3).
  - Drive the stores with 0, 2 and 5 idle cycles between them, plus back-to-back repeats in a second run.
  - Required: pass, with `busy` low one cycle after the 88/3 store.
  - Variant swapping the last two stores: `fail_idx=1`, `fail_addr=88`, `fail_data=3`.
- **Empty table:** count 0, pulse `start`. Result: `done=pass=1` one cycle later; a concurrent store to 84 is ignored.
- **Reset mid-RUN:** assert `reset` after one of three stores. All outputs are 0 immediately, state is IDLE, and a table read-back gives 0. A fresh `start` with count 0 then passes.
- **Watchdog** (macro defined, `TIMEOUT=16`): `start`, no stores. FAIL after 16 RUN cycles with `timeout=1`. Variant with a matching final store on cycle 16: pass, `timeout=0`.
